// File: rtl/rgb_pwm_driver_pkg.sv
// Shared types and constants for the RGB PWM driver and the colour sequencer.
package rgb_pwm_driver_pkg;

    localparam int DUTY_W  = 8;
    localparam int PRESC_W = 16;

    typedef logic [DUTY_W-1:0] duty_t;

    // Last value of the period counter; a period is PWM_PERIOD_LAST+1 = 255 ticks.
    localparam duty_t PWM_PERIOD_LAST = 8'd254;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } pwm_state_e;

    typedef struct packed {
        duty_t r;
        duty_t g;
        duty_t b;
    } duty_rgb_t;

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// Duty-update handshake between the colour sequencer and the PWM driver.
interface rgb_pwm_driver_if;
    import rgb_pwm_driver_pkg::*;

    logic  upd_valid;
    logic  upd_ready;
    duty_t duty_r;
    duty_t duty_g;
    duty_t duty_b;

    modport master (
        output upd_valid,
        output duty_r,
        output duty_g,
        output duty_b,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  duty_r,
        input  duty_g,
        input  duty_b,
        output upd_ready
    );

endinterface

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM colour channel: compare, pin polarity and output register.
// The compare uses the counter/duty values the top is about to load, so the
// registered pin lines up exactly with the registered period counter.
module pwm_channel
    import rgb_pwm_driver_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  ld,
    input  logic  act,
    input  duty_t pcnt_nx,
    input  duty_t duty_nx,
    output logic  pwm
);

    // Pin register: updated only on tick / run-entry clocks so it never glitches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm <= ACTIVE_LOW;
        end else if (ld) begin
            pwm <= (act && (pcnt_nx < duty_nx)) ^ ACTIVE_LOW;
        end
    end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel RGB PWM driver: prescaler, 255-tick period counter, run/stop
// FSM and a one-deep duty update buffer applied only at period boundaries.
module rgb_pwm_driver
    import rgb_pwm_driver_pkg::*;
#(
    parameter int unsigned PRESCALE   = 4,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    rgb_pwm_driver_if.slave upd,
    output logic            pwm_r,
    output logic            pwm_g,
    output logic            pwm_b,
    output logic            period_start,
    output logic            running
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

    logic               rst_sync_p0;
    logic               rst_sync_p1;

    pwm_state_e         state_q;
    pwm_state_e         state_nx;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_nx;
    duty_t              pcnt_q;
    duty_t              pcnt_nx;
    duty_rgb_t          act_q;
    duty_rgb_t          act_nx;
    duty_rgb_t          pend_q;
    duty_rgb_t          pend_nx;
    logic               ready_q;
    logic               ready_nx;
    logic               pstart_nx;
    logic               run_nx;
    logic               tick;
    logic               wrap;
    logic               accept;
    logic               ld;

    assign upd.upd_ready = ready_q;

    // Reset release synchroniser: assertion is immediate, release reaches the FSM two clocks later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_p0 <= 1'b0;
            rst_sync_p1 <= 1'b0;
        end else begin
            rst_sync_p0 <= 1'b1;
            rst_sync_p1 <= rst_sync_p0;
        end
    end

    // Next-state logic for the FSM, counters and update buffer.
    always_comb begin
        state_nx  = state_q;
        presc_nx  = presc_q;
        pcnt_nx   = pcnt_q;
        act_nx    = act_q;
        pend_nx   = pend_q;
        ready_nx  = ready_q;
        pstart_nx = 1'b0;
        ld        = 1'b0;
        tick      = (state_q != ST_IDLE) && (presc_q == PRESC_LAST);
        wrap      = tick && (pcnt_q == PWM_PERIOD_LAST);
        accept    = upd.upd_valid && ready_q;

        // Accept and apply never coincide: accept needs an empty buffer,
        // apply needs a full one, so a triple taken on a wrap waits a period.
        if (accept) begin
            pend_nx  = {upd.duty_r, upd.duty_g, upd.duty_b};
            ready_nx = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (en && rst_sync_p1) begin
                    state_nx  = ST_RUN;
                    presc_nx  = '0;
                    pcnt_nx   = '0;
                    pstart_nx = 1'b1;
                    ld        = 1'b1;
                    if (!ready_q) begin
                        act_nx   = pend_q;
                        ready_nx = 1'b1;
                    end
                end
            end
            ST_RUN, ST_STOPPING: begin
                if (tick) begin
                    presc_nx = '0;
                    pcnt_nx  = wrap ? '0 : pcnt_q + 8'd1;
                    ld       = 1'b1;
                end else begin
                    presc_nx = presc_q + 16'd1;
                end
                if (wrap && !ready_q) begin
                    act_nx   = pend_q;
                    ready_nx = 1'b1;
                end
                if (en) begin
                    state_nx  = ST_RUN;
                    pstart_nx = wrap;
                end else if (state_q == ST_RUN) begin
                    // Stopping still finishes the current period and, if the
                    // drop lands on a wrap, the whole next one.
                    state_nx  = ST_STOPPING;
                    pstart_nx = wrap;
                end else if (wrap) begin
                    state_nx = ST_IDLE;
                    pcnt_nx  = '0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        run_nx = (state_nx != ST_IDLE);
    end

    // FSM and control registers with their registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            pcnt_q       <= '0;
            act_q        <= '0;
            ready_q      <= 1'b1;
            period_start <= 1'b0;
            running      <= 1'b0;
        end else begin
            state_q      <= state_nx;
            presc_q      <= presc_nx;
            pcnt_q       <= pcnt_nx;
            act_q        <= act_nx;
            ready_q      <= ready_nx;
            period_start <= pstart_nx;
            running      <= run_nx;
        end
    end

    // Pending triple storage; its content is only meaningful while upd_ready is low.
    always_ff @(posedge clk) begin
        pend_q <= pend_nx;
    end

    pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_ch_r (
        .clk     (clk),
        .rst     (rst),
        .ld      (ld),
        .act     (run_nx),
        .pcnt_nx (pcnt_nx),
        .duty_nx (act_nx.r),
        .pwm     (pwm_r)
    );

    pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_ch_g (
        .clk     (clk),
        .rst     (rst),
        .ld      (ld),
        .act     (run_nx),
        .pcnt_nx (pcnt_nx),
        .duty_nx (act_nx.g),
        .pwm     (pwm_g)
    );

    pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_ch_b (
        .clk     (clk),
        .rst     (rst),
        .ld      (ld),
        .act     (run_nx),
        .pcnt_nx (pcnt_nx),
        .duty_nx (act_nx.b),
        .pwm     (pwm_b)
    );

endmodule

// File: doc/rgb_pwm_driver.md
RGB_PWM_DRIVER -- requirements
Module: rgb_pwm_driver

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter: PRESCALE, 4, clk cycles per PWM tick (legal 1..65535).
REQ-003 Parameter: ACTIVE_LOW, 0, 1 inverts pwm_r/g/b at the pins (common-anode LED).
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  run request; low stops PWM at the next period end.
REQ-007 upd_valid  input  1  new duty triple offered.
REQ-008 upd_ready  output  1  pending buffer empty; triple accepted when upd_valid && upd_ready.
REQ-009 duty_r, duty_g, duty_b  input  8 each  duty values (upstream colour sequencer R/G/B_time_out).
REQ-010 pwm_r, pwm_g, pwm_b  output  1 each  PWM drive after ACTIVE_LOW polarity.
REQ-011 period_start  output  1  one-clk pulse on the clk where tick count returns to 0 in RUN.
REQ-012 running  output  1  high in RUN and STOPPING.

Function
REQ-013 Prescaler SHALL count 0..PRESCALE-1 and assert a one-clk tick on terminal count; it counts only in RUN/STOPPING and is held at 0 in IDLE.
REQ-014 Period counter pcnt SHALL be 8 bits, advance on tick, wrap 254 -> 0 (period = 255 ticks = 255*PRESCALE clks).
REQ-015 Raw output per channel SHALL be (pcnt < active_duty); duty 0 = always off, duty 255 = always on, duty N = N ticks high per period.
REQ-016 Handshake: on accept, triple SHALL be stored in a one-deep pending buffer and upd_ready SHALL drop the next clk.
REQ-017 Pending triple SHALL be copied to active_duty only on the tick that wraps pcnt to 0 (or on IDLE->RUN entry); upd_ready SHALL rise the following clk.
REQ-018 Accept and wrap on the same clk: the accepted triple SHALL be applied at the next wrap, not the current one.
REQ-019 upd_valid while upd_ready low SHALL be ignored (no overwrite); upstream holds data until accepted.
REQ-020 FSM states IDLE, RUN, STOPPING.
REQ-021 IDLE -> RUN when en=1: pcnt=0, prescaler=0, pending (if any) applied, period_start pulses same clk.
REQ-022 RUN -> STOPPING when en=0; STOPPING -> IDLE on the wrap tick; STOPPING -> RUN if en=1 again before wrap (no discontinuity).
REQ-023 In IDLE raw outputs SHALL be 0 (pins = ACTIVE_LOW); upd handshake SHALL remain functional.
REQ-024 Outputs SHALL be registered; glitch-free; change only on tick clks.

Reset
REQ-025 On rst low: state=IDLE, pcnt=0, prescaler=0, active_duty=0, pending empty, upd_ready=1, period_start=0, running=0, pwm_* = ACTIVE_LOW.
REQ-026 Reset mid-period SHALL take effect immediately (asynchronous); deassertion SHALL be synchronised through a 2-flop chain before releasing the FSM.

Structure
REQ-027 Shared package SHALL hold the FSM state enum, PWM_PERIOD_LAST=254 and duty width 8, shared with the colour sequencer.
REQ-028 One sub-module pwm_channel (compare + polarity + output register) SHALL be instantiated three times; prescaler, counter, FSM and handshake stay in the top.

Verification
REQ-029 PRESCALE=1, en=1, duty (0,128,255) -> pwm_r never high, pwm_g high exactly 128 of 255 clks, pwm_b never low.
REQ-030 Running with duty_r=10; offer 200 mid-period -> upd_ready low next clk; pwm_r stays 10-tick width until wrap; 200-tick width from next period_start; upd_ready high clk after wrap.
REQ-031 Offer triple on the exact wrap clk -> applied one full period later; second offer while upd_ready=0 -> ignored, first value applied.
REQ-032 Drop en at pcnt=100 -> running stays 1 until wrap, then IDLE, pins = ACTIVE_LOW; re-raise en at pcnt=200 in STOPPING -> no gap, pcnt continues 201.
REQ-033 ACTIVE_LOW=1, PRESCALE=4, duty_g=3 -> pwm_g low for 12 clks per 1020-clk period.
REQ-034 Assert rst at pcnt=50 -> all outputs at reset values same clk without clk edge; after release + en, period_start pulses and pcnt restarts at 0.
